filtro_chaves: RTL and testbench
================================

FILTRO_CHAVES -- requirements
Module: filtro_chaves

Interface
REQ-001 SHALL have parameter LARGURA, default 8: number of switch inputs, sized to match the 8-bit switch input of the ones-counting adder.
REQ-002 SHALL have parameter CICLOS_ESTAVEL, default 16: consecutive clock cycles a switch must hold a new level before it is accepted; legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port chaves_brutas, input, LARGURA bits: raw, asynchronous, bouncing switch levels.
REQ-006 SHALL have port chaves, output, LARGURA bits: debounced switch levels, registered, driving the adder's chaves input directly.
REQ-007 SHALL have port mudou, output, 1 bit: one-cycle pulse marking that chaves changed.
REQ-008 SHALL have port estavel, output, 1 bit: high when no bit has a pending change.

Function
REQ-009 SHALL pass each bit of chaves_brutas through a 2-flop synchronizer (sinc1 then sinc2) before any comparison.
REQ-010 SHALL keep one counter per bit, wide enough to hold CICLOS_ESTAVEL.
REQ-011 SHALL clear a bit's counter on any edge where sinc2[i] == chaves[i]; pending change is abandoned.
REQ-012 SHALL increment a bit's counter on each edge where sinc2[i] != chaves[i].
REQ-013 SHALL load chaves[i] <= sinc2[i] and clear counter[i] on the CICLOS_ESTAVEL-th consecutive edge of disagreement.
REQ-014 SHALL meet this latency: a level sampled into sinc1 at edge k, then held, appears on chaves at edge k+1+CICLOS_ESTAVEL.
REQ-015 SHALL restart the count from zero on any bounce shorter than CICLOS_ESTAVEL cycles.
REQ-016 SHALL leave chaves unchanged after such a short bounce.
REQ-017 SHALL keep bits independent: several bits may be pending, and may update on the same edge.
REQ-018 SHALL assert mudou for exactly the one cycle following an edge on which at least one chaves bit was loaded with a new value.
REQ-019 SHALL assert only a single mudou pulse when several bits update on the same edge.
REQ-020 SHALL assert mudou back-to-back when updates occur on consecutive edges.
REQ-021 SHALL drive estavel = 1 when, for all i, sinc2[i] == chaves[i] and counter[i] == 0.
REQ-022 SHALL decode estavel from registers only, with no combinational path from chaves_brutas.
REQ-023 SHALL keep chaves glitch-free: it changes only at clock edges, never mid-cycle.

Reset
REQ-024 SHALL, while rst = 1, immediately force sinc1, sinc2, chaves, all counters and mudou to 0, independent of clk.
REQ-025 SHALL drive estavel to 1 while in reset.
REQ-026 SHALL, when rst is asserted mid-debounce, discard the pending change; counting restarts after release.
REQ-027 SHALL act on the first rising edge after rst deasserts as a normal sampling edge.

Structure
REQ-028 SHALL place constants LARGURA_CHAVES = 8 and CICLOS_ESTAVEL_PADRAO = 16 in a shared package, used by this block and the adder's top level.
REQ-029 SHALL implement the per-bit datapath (synchronizer, counter, output flop, update flag) as sub-module filtro_bit, instantiated LARGURA times via generate.
REQ-030 SHALL form mudou as the registered OR of the filtro_bit update flags; estavel is the AND of the per-bit idle flags.

Verification (CICLOS_ESTAVEL = 4 unless stated)
REQ-031 SHALL cover clean press: after reset, chaves_brutas = 8'h01 held from before edge 0 -> chaves = 8'h01 at edge 5; mudou high for exactly one cycle; estavel low during edges 2..4.
REQ-032 SHALL cover bounce rejection: bit 3 toggles 1,0,1,0 with each level held 2 cycles, then returns to 0 -> chaves stays 8'h00; mudou never asserts.
REQ-033 SHALL cover simultaneous change: chaves_brutas 8'h00 -> 8'hFF in one cycle -> chaves = 8'hFF on a single edge; one mudou pulse; downstream adder output = 8.
REQ-034 SHALL cover staggered bits: bit 0 rises at edge 0 and bit 7 at edge 1 -> chaves = 8'h01 at edge 5 and 8'h81 at edge 6; mudou high two consecutive cycles.
REQ-035 SHALL cover reset mid-debounce: chaves_brutas = 8'h10, rst pulsed between edges 3 and 4 -> chaves = 0 immediately; 8'h10 accepted 5 edges after the first post-reset edge.
REQ-036 SHALL cover parameter sweep: CICLOS_ESTAVEL = 2 and 16 -> REQ-014 latency holds exactly; no X on any output after reset.

Source files
------------

// File: rtl/filtro_chaves_pkg.sv
// Shared constants for the switch debouncer and the ones-counting adder top level.
// Both blocks size their switch buses and default debounce time from here.
package filtro_chaves_pkg;

  localparam int LARGURA_CHAVES        = 8;
  localparam int CICLOS_ESTAVEL_PADRAO = 16;

  typedef logic [LARGURA_CHAVES-1:0] chaves_t;

  // The counter must be able to represent CICLOS_ESTAVEL itself.
  function automatic int largura_contador(input int ciclos);
    return $clog2(ciclos + 1);
  endfunction

endpackage

// File: rtl/filtro_bit.sv
// One debounced switch: 2-flop synchronizer, disagreement counter and output flop.
// atualiza flags the edge on which chave takes a new value; ocioso means nothing pending.
module filtro_bit
  import filtro_chaves_pkg::*;
#(
  parameter int CICLOS_ESTAVEL = CICLOS_ESTAVEL_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic bruta,
  output logic chave,
  output logic atualiza,
  output logic ocioso
);

  localparam int              LC       = largura_contador(CICLOS_ESTAVEL);
  localparam logic [LC-1:0]   TERMINAL = LC'(CICLOS_ESTAVEL - 1);

  logic          sinc1;
  logic          sinc2;
  logic [LC-1:0] contador;
  logic          diverge;

  assign diverge  = (sinc2 != chave);
  // The CICLOS_ESTAVEL-th disagreeing edge is the one that sees contador at CICLOS_ESTAVEL-1.
  assign atualiza = diverge && (contador == TERMINAL);
  assign ocioso   = !diverge && (contador == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= bruta;
      sinc2 <= sinc1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chave    <= 1'b0;
      contador <= '0;
    end else if (!diverge) begin
      contador <= '0;
    end else if (atualiza) begin
      chave    <= sinc2;
      contador <= '0;
    end else begin
      contador <= contador + LC'(1);
    end
  end

endmodule

// File: rtl/filtro_chaves.sv
// Debouncer for a bank of bouncing switches feeding the ones-counting adder.
// Each bit is filtered independently; mudou pulses once per edge that changed any bit.
module filtro_chaves
  import filtro_chaves_pkg::*;
#(
  parameter int LARGURA        = LARGURA_CHAVES,
  parameter int CICLOS_ESTAVEL = CICLOS_ESTAVEL_PADRAO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] chaves_brutas,
  output logic [LARGURA-1:0] chaves,
  output logic               mudou,
  output logic               estavel
);

  logic [LARGURA-1:0] atualiza;
  logic [LARGURA-1:0] ocioso;

  for (genvar i = 0; i < LARGURA; i++) begin : g_bit
    filtro_bit #(
      .CICLOS_ESTAVEL(CICLOS_ESTAVEL)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .bruta   (chaves_brutas[i]),
      .chave   (chaves[i]),
      .atualiza(atualiza[i]),
      .ocioso  (ocioso[i])
    );
  end

  // Registered alongside chaves, so the pulse lines up with the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mudou <= 1'b0;
    else     mudou <= |atualiza;
  end

  assign estavel = &ocioso;

endmodule

// File: tb/tb_filtro_chaves.sv
// Directed bench for filtro_chaves: main instance with CICLOS_ESTAVEL = 4,
// plus instances with 2 and 16 to check the latency formula at both ends.
module tb_filtro_chaves;
  import filtro_chaves_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] brutas = '0, brutas2 = '0, brutas16 = '0;
  logic [7:0] chaves, chaves2, chaves16;
  logic       mudou, mudou2, mudou16;
  logic       estavel, estavel2, estavel16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  filtro_chaves #(.LARGURA(8), .CICLOS_ESTAVEL(4)) dut (
    .clk(clk), .rst(rst), .chaves_brutas(brutas),
    .chaves(chaves), .mudou(mudou), .estavel(estavel));

  filtro_chaves #(.LARGURA(8), .CICLOS_ESTAVEL(2)) dut2 (
    .clk(clk), .rst(rst), .chaves_brutas(brutas2),
    .chaves(chaves2), .mudou(mudou2), .estavel(estavel2));

  filtro_chaves #(.LARGURA(8), .CICLOS_ESTAVEL(16)) dut16 (
    .clk(clk), .rst(rst), .chaves_brutas(brutas16),
    .chaves(chaves16), .mudou(mudou16), .estavel(estavel16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulsos;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_chaves", {24'd0, chaves}, 32'h00);
    check("rst_mudou", {31'd0, mudou}, 32'd0);
    check("rst_estavel", {31'd0, estavel}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_estavel_rel", {31'd0, estavel}, 32'd1);

    // Clean press on all three instances; latency k+1+C
    brutas = 8'h01; brutas2 = 8'h01; brutas16 = 8'h01;
    for (int e = 0; e <= 17; e++) begin
      tick();
      check($sformatf("press_chaves_e%0d", e), {24'd0, chaves}, (e >= 5) ? 32'h01 : 32'h00);
      check($sformatf("press_mudou_e%0d", e), {31'd0, mudou}, (e == 5) ? 32'd1 : 32'd0);
      if (e >= 1 && e <= 4)
        check($sformatf("press_estavel_e%0d", e), {31'd0, estavel}, 32'd0);
      if (e == 5)
        check("press_estavel_e5", {31'd0, estavel}, 32'd1);
      check($sformatf("c2_chaves_e%0d", e), {24'd0, chaves2}, (e >= 3) ? 32'h01 : 32'h00);
      check($sformatf("c2_mudou_e%0d", e), {31'd0, mudou2}, (e == 3) ? 32'd1 : 32'd0);
      check($sformatf("c16_chaves_e%0d", e), {24'd0, chaves16}, (e >= 17) ? 32'h01 : 32'h00);
      check($sformatf("c16_mudou_e%0d", e), {31'd0, mudou16}, (e == 17) ? 32'd1 : 32'd0);
      check($sformatf("no_x_e%0d", e),
            {31'd0, $isunknown({chaves, chaves2, chaves16, mudou, mudou2, mudou16,
                                estavel, estavel2, estavel16})}, 32'd0);
    end

    // Bounce rejection on bit 3: 1,0,1,0 each held 2 cycles
    for (int s = 0; s < 14; s++) begin
      brutas = (s < 8 && (s % 4) < 2) ? 8'h09 : 8'h01;
      tick();
      check($sformatf("bounce_chaves_s%0d", s), {24'd0, chaves}, 32'h01);
      check($sformatf("bounce_mudou_s%0d", s), {31'd0, mudou}, 32'd0);
    end
    check("bounce_estavel", {31'd0, estavel}, 32'd1);

    // Simultaneous change 00 -> FF
    brutas = 8'h00;
    repeat (8) tick();
    check("simul_pre", {24'd0, chaves}, 32'h00);
    brutas = 8'hFF;
    pulsos = 0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (mudou) pulsos++;
      check($sformatf("simul_chaves_e%0d", e), {24'd0, chaves}, (e >= 5) ? 32'hFF : 32'h00);
    end
    check("simul_pulsos", pulsos, 32'd1);
    check("simul_soma", $countones(chaves), 32'd8);

    // Staggered: bit 0 at edge 0, bit 7 at edge 1
    brutas = 8'h00;
    repeat (8) tick();
    check("stag_pre", {24'd0, chaves}, 32'h00);
    brutas = 8'h01;
    tick();
    brutas = 8'h81;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("stag_chaves_e%0d", e), {24'd0, chaves},
            (e >= 6) ? 32'h81 : ((e == 5) ? 32'h01 : 32'h00));
      check($sformatf("stag_mudou_e%0d", e), {31'd0, mudou},
            (e == 5 || e == 6) ? 32'd1 : 32'd0);
    end

    // Reset mid-debounce
    brutas = 8'h00;
    repeat (8) tick();
    check("rmid_pre", {24'd0, chaves}, 32'h00);
    brutas = 8'h10;
    repeat (4) tick();
    check("rmid_e3_chaves", {24'd0, chaves}, 32'h00);
    check("rmid_e3_estavel", {31'd0, estavel}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rmid_rst_chaves", {24'd0, chaves}, 32'h00);
    check("rmid_rst_estavel", {31'd0, estavel}, 32'd1);
    #1 rst = 1'b0;
    for (int p = 0; p <= 6; p++) begin
      tick();
      check($sformatf("rmid_chaves_p%0d", p), {24'd0, chaves}, (p >= 5) ? 32'h10 : 32'h00);
      check($sformatf("rmid_mudou_p%0d", p), {31'd0, mudou}, (p == 5) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
